uart_tx: RTL and testbench

Memory-mapped UART transmitter for the PicoRV32 native memory bus. It is the transmit companion of the UART receiver and sits at XXXX_XX40 behind the same external address decode, which drives `enable`. The CPU writes bytes into a small FIFO. A single-clock serializer emits them as 8N1 frames on `serial_out`, and software polls a status word for full and busy.

---
 rtl/uart_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 transmitter for the PicoRV32 native bus.
// The CPU pushes bytes into a small FIFO. A single-clock serializer drains
// the FIFO onto serial_out. A status word reports busy and full.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line high, waiting for the FIFO to become non-empty
// START | start bit (low) being held for one bit period
// DATA  | data bits, LSB first, bit_idx selects the bit on the line
// STOP  | stop bit (high), then chain straight into the next frame
module uart_tx #(
    parameter int BAUD_DIVIDER = 433,
    parameter int FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    output logic        serial_out
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]      BAUD_TC   = 16'(BAUD_DIVIDER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Address decode is external and only the low data byte is transmitted.
    logic unused_inputs;
    assign unused_inputs = ^{mem_instr, mem_addr, mem_wdata[31:8]};

    // ------------------------------------------------------------------
    // Bus handshake
    // ------------------------------------------------------------------
    logic is_write;
    logic req;
    logic accept;
    logic push;
    logic full;
    logic empty;
    logic busy;

    assign is_write = |mem_wstrb;
    // mem_ready gates a fresh request so the acknowledge is a single-cycle pulse.
    assign req      = mem_valid & enable & ~mem_ready;
    // A write to a full FIFO simply waits; nothing is ever dropped.
    assign accept   = req & (~is_write | ~full);
    assign push     = accept & is_write;

    // Registered acknowledge, one cycle after the request is taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= accept;
        end
    end

    // ------------------------------------------------------------------
    // FIFO: circular buffer with wrapping pointers and an occupancy count
    // ------------------------------------------------------------------
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               pop;
    logic [7:0]         fifo_head;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign fifo_head = fifo_mem[rd_ptr];

    // Storage array; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_wdata[7:0];
        end
    end

    // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    logic [15:0] timer;
    logic [15:0] timer_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_next;
    logic [7:0]  shift;
    logic [7:0]  shift_next;
    logic        tx_next;
    logic        tick;

    assign tick = (timer == BAUD_TC);

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            serial_out <= tx_next;
        end
    end

    // Next-state decode: bit-period ticks advance the frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = empty ? IDLE : START;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: pop, bit timer, shift register and next line level.
    always_comb begin
        pop          = 1'b0;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = serial_out;
        case (state)
            IDLE: begin
                tx_next    = 1'b1;
                timer_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    timer_next   = '0;
                    bit_idx_next = '0;
                    tx_next      = shift[0];
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next = 1'b1;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift[1];
                    end
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    timer_next = '0;
                    if (!empty) begin
                        // Chain the next frame with no idle gap.
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        tx_next    = 1'b0;
                    end else begin
                        tx_next = 1'b1;
                    end
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            default: begin
                tx_next    = 1'b1;
                timer_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status word
    // ------------------------------------------------------------------
    assign busy      = ~empty | (state != IDLE);
    assign mem_rdata = enable ? {22'b0, busy, full, 8'b0} : 32'b0;

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int D0 = 3;
    localparam int D1 = 1;
    localparam int AW = 2;

    typedef logic [7:0] byte_q_t[$];
    typedef bit bit_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, enable, mem_valid, mem_ready, mem_instr, serial_out;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata, mem_addr, mem_rdata;

    logic        b_resetn, b_enable, b_mem_valid, b_mem_ready, b_mem_instr, b_serial_out;
    logic [3:0]  b_mem_wstrb;
    logic [31:0] b_mem_wdata, b_mem_addr, b_mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    bit_q_t line_log;
    bit_q_t line_log1;

    uart_tx #(.BAUD_DIVIDER(D0), .FIFO_AW(AW)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .serial_out(serial_out)
    );

    uart_tx #(.BAUD_DIVIDER(D1), .FIFO_AW(AW)) dut_fast (
        .clk(clk), .resetn(b_resetn), .enable(b_enable), .mem_valid(b_mem_valid),
        .mem_ready(b_mem_ready), .mem_instr(b_mem_instr), .mem_wstrb(b_mem_wstrb),
        .mem_wdata(b_mem_wdata), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
        .serial_out(b_serial_out)
    );

    // One line sample per clock cycle, taken mid-cycle.
    always @(negedge clk) begin
        line_log.push_back(serial_out);
        line_log1.push_back(b_serial_out);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Reference model: an 8N1 frame is {stop=1, data LSB first, start=0}, each bit
    // held d+1 cycles, frames contiguous, idle-high on both sides of the burst.
    function automatic int line_errors(input bit_q_t lg, input int start,
                                       input byte_q_t bytes, input int d);
        int bl    = d + 1;
        int fl    = 10 * bl;
        int total = bytes.size() * fl;
        int errs  = 0;
        for (int c = -1; c <= total; c++) begin
            bit exp;
            int f, pos;
            if (c < 0 || c == total) begin
                exp = 1'b1;
            end else begin
                f   = c / fl;
                pos = (c % fl) / bl;
                if (pos == 0)      exp = 1'b0;
                else if (pos == 9) exp = 1'b1;
                else               exp = bytes[f][pos-1];
            end
            if (start + c < 0 || start + c >= lg.size()) errs++;
            else if (lg[start+c] !== exp) errs++;
        end
        return errs;
    endfunction

    // Receiver-style decode: find start bits, sample each bit mid-period.
    task automatic decode_line(input bit_q_t lg, input int from, input int d,
                               output byte_q_t out, output int ferr);
        int bl = d + 1;
        int i  = from;
        logic [7:0] b;
        out  = {};
        ferr = 0;
        while (i < lg.size()) begin
            if (lg[i] == 1'b0) begin
                if (i + 10 * bl > lg.size()) break;
                for (int j = 0; j < 8; j++) b[j] = lg[i + (j + 1) * bl + bl / 2];
                if (lg[i + 9 * bl + bl / 2] != 1'b1) ferr++;
                out.push_back(b);
                i = i + 9 * bl + bl / 2 + 1;
            end else begin
                i++;
            end
        end
    endtask

    task automatic wait_log(input bit fast, input int n);
        int g = 0;
        while (((fast ? line_log1.size() : line_log.size()) < n) && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
    endtask

    task automatic bus_write(input logic [7:0] data, input logic [3:0] strb,
                             output int idx, output int waited, output bit pulse_ok);
        mem_wdata      = $urandom();
        mem_wdata[7:0] = data;
        mem_addr       = $urandom();
        mem_instr      = 1'($urandom_range(0, 1));
        mem_wstrb      = strb;
        enable         = 1'b1;
        mem_valid      = 1'b1;
        waited         = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!mem_ready && waited < 400);
        idx       = line_log.size();
        mem_valid = 1'b0;
        enable    = 1'b0;
        mem_wstrb = 4'h0;
        @(posedge clk); #1;
        pulse_ok = !mem_ready;
    endtask

    task automatic bus_read(output logic [31:0] d, output int c, output bit ack,
                            output bit pulse_ok);
        mem_wstrb = 4'h0;
        mem_addr  = $urandom();
        enable    = 1'b1;
        mem_valid = 1'b1;
        #1;
        d = mem_rdata;
        c = line_log.size();
        @(posedge clk); #1;
        ack       = mem_ready;
        mem_valid = 1'b0;
        enable    = 1'b0;
        @(posedge clk); #1;
        pulse_ok = !mem_ready;
    endtask

    task automatic b_write(input logic [7:0] data, output int idx, output int waited);
        b_mem_wdata      = $urandom();
        b_mem_wdata[7:0] = data;
        b_mem_addr       = $urandom();
        b_mem_wstrb      = 4'hF;
        b_enable         = 1'b1;
        b_mem_valid      = 1'b1;
        waited           = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!b_mem_ready && waited < 400);
        idx         = line_log1.size();
        b_mem_valid = 1'b0;
        b_enable    = 1'b0;
        b_mem_wstrb = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int c;
        bit ack, p;
        resetn = 1'b1; b_resetn = 1'b1;
        enable = 1'b0; mem_valid = 1'b0; mem_wstrb = '0; mem_wdata = '0; mem_addr = '0; mem_instr = 1'b0;
        b_enable = 1'b0; b_mem_valid = 1'b0; b_mem_wstrb = '0; b_mem_wdata = '0; b_mem_addr = '0; b_mem_instr = 1'b0;
        #2;
        resetn = 1'b0; b_resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1; b_resetn = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (serial_out !== 1'b1) $display("FAIL reset_line: got %b want 1", serial_out); else n_pass++;
        n_checks++; if (mem_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", mem_ready); else n_pass++;
        n_checks++; if (mem_rdata !== 32'h0) $display("FAIL reset_rdata_disabled: got %h want 0", mem_rdata); else n_pass++;
        n_checks++; if (b_serial_out !== 1'b1) $display("FAIL reset_line_fast: got %b want 1", b_serial_out); else n_pass++;
        bus_read(rd, c, ack, p);
        n_checks++; if (rd !== 32'h0) $display("FAIL reset_status: got %h want 00000000", rd); else n_pass++;
        n_checks++; if (ack !== 1'b1) $display("FAIL read_ack_latency: got %b want 1", ack); else n_pass++;
        n_checks++; if (p !== 1'b1) $display("FAIL read_ready_pulse: ready still high, want low"); else n_pass++;
    endtask

    task automatic test_single();
        int k, w, errs, c;
        bit p, ack;
        logic [31:0] rd;
        byte_q_t q;
        q = {8'h55};
        bus_write(8'h55, 4'hF, k, w, p);
        n_checks++; if (w !== 1) $display("FAIL single_ack_latency: got %0d want 1", w); else n_pass++;
        n_checks++; if (p !== 1'b1) $display("FAIL single_ready_pulse: ready high 2nd cycle, want low"); else n_pass++;
        wait_log(1'b0, k + 1 + 40 + 2);
        errs = line_errors(line_log, k + 1, q, D0);
        n_checks++; if (errs !== 0) $display("FAIL single_frame_0x55: %0d bad cycles, want 0", errs); else n_pass++;
        bus_read(rd, c, ack, p);
        n_checks++; if (rd !== 32'h0) $display("FAIL single_idle_status: got %h want 00000000", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int k, k2, w, errs, c, bad, polls;
        bit p, ack;
        logic [31:0] rd;
        byte_q_t q;
        q = {8'hA3, 8'h00, 8'hFF};
        bus_write(q[0], 4'hF, k, w, p);
        bus_write(q[1], 4'hF, k2, w, p);
        n_checks++; if (w !== 1) $display("FAIL b2b_ack_latency_2: got %0d want 1", w); else n_pass++;
        bus_write(q[2], 4'hF, k2, w, p);
        n_checks++; if (w !== 1) $display("FAIL b2b_ack_latency_3: got %0d want 1", w); else n_pass++;
        bad = 0; polls = 0;
        do begin
            bus_read(rd, c, ack, p);
            if (rd[9] !== (c < k + 1 + 120) || rd[8] !== 1'b0 || ack !== 1'b1) bad++;
            polls++;
        end while (rd[9] === 1'b1 && polls < 200);
        n_checks++; if (bad !== 0) $display("FAIL b2b_busy_track: %0d bad polls, want 0", bad); else n_pass++;
        n_checks++; if (rd[9] !== 1'b0) $display("FAIL b2b_busy_falls: got %b want 0", rd[9]); else n_pass++;
        wait_log(1'b0, k + 1 + 120 + 2);
        errs = line_errors(line_log, k + 1, q, D0);
        n_checks++; if (errs !== 0) $display("FAIL b2b_frames: %0d bad cycles, want 0", errs); else n_pass++;
    endtask

    task automatic test_fifo_full();
        int k, k1, k6, w, errs, c, badlat;
        bit p, ack;
        logic [31:0] rd;
        byte_q_t q;
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom()));
        badlat = 0; k1 = 0;
        for (int i = 0; i < 5; i++) begin
            bus_write(q[i], 4'hF, k, w, p);
            if (i == 0) k1 = k;
            if (w != 1 || !p) badlat++;
        end
        n_checks++; if (badlat !== 0) $display("FAIL full_fill_latency: %0d slow acks, want 0", badlat); else n_pass++;
        bus_read(rd, c, ack, p);
        n_checks++; if (rd !== 32'h300) $display("FAIL full_stall_status: got %h want 00000300", rd); else n_pass++;
        bus_write(q[5], 4'hF, k6, w, p);
        n_checks++; if (k6 !== k1 + 42) $display("FAIL full_release_cycle: got %0d want %0d", k6 - k1, 42); else n_pass++;
        wait_log(1'b0, k1 + 1 + 240 + 2);
        errs = line_errors(line_log, k1 + 1, q, D0);
        n_checks++; if (errs !== 0) $display("FAIL full_six_frames: %0d bad cycles, want 0", errs); else n_pass++;
    endtask

    task automatic test_enable_gating();
        int s, hits, bad_rd, lows, k, w, errs, c;
        bit p, ack;
        logic [31:0] rd;
        logic [7:0] b;
        byte_q_t q;
        s = line_log.size();
        mem_valid = 1'b1; enable = 1'b0; mem_wstrb = 4'hF; mem_wdata = $urandom();
        hits = 0; bad_rd = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mem_ready !== 1'b0) hits++;
            if (mem_rdata !== 32'h0) bad_rd++;
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        n_checks++; if (hits !== 0) $display("FAIL disabled_no_ready: %0d ready cycles, want 0", hits); else n_pass++;
        n_checks++; if (bad_rd !== 0) $display("FAIL disabled_rdata_zero: %0d nonzero cycles, want 0", bad_rd); else n_pass++;
        repeat (50) begin @(posedge clk); #1; end
        lows = 0;
        for (int i = s; i < line_log.size(); i++) if (line_log[i] !== 1'b1) lows++;
        n_checks++; if (lows !== 0) $display("FAIL disabled_no_push: %0d low cycles, want 0", lows); else n_pass++;
        bus_read(rd, c, ack, p);
        n_checks++; if (rd !== 32'h0) $display("FAIL disabled_status: got %h want 00000000", rd); else n_pass++;
        b = 8'($urandom());
        q = {b};
        bus_write(b, 4'b0100, k, w, p);
        n_checks++; if (w !== 1) $display("FAIL strb0100_ack: got %0d want 1", w); else n_pass++;
        wait_log(1'b0, k + 1 + 40 + 2);
        errs = line_errors(line_log, k + 1, q, D0);
        n_checks++; if (errs !== 0) $display("FAIL strb0100_frame: %0d bad cycles, want 0", errs); else n_pass++;
    endtask

    task automatic test_random();
        int from, k, w, c, polls, ferr, bad, slow;
        bit p, ack;
        logic [31:0] rd;
        byte_q_t q, got;
        q = {};
        for (int i = 0; i < 10; i++) q.push_back(8'($urandom()));
        from = line_log.size();
        slow = 0;
        for (int i = 0; i < 10; i++) begin
            bus_write(q[i], 4'($urandom_range(1, 15)), k, w, p);
            if (w >= 400) slow++;
            repeat ($urandom_range(0, 60)) begin @(posedge clk); #1; end
        end
        n_checks++; if (slow !== 0) $display("FAIL random_write_timeout: %0d writes, want 0", slow); else n_pass++;
        polls = 0;
        do begin
            bus_read(rd, c, ack, p);
            polls++;
        end while (rd[9] === 1'b1 && polls < 300);
        repeat (4) begin @(posedge clk); #1; end
        decode_line(line_log, from, D0, got, ferr);
        n_checks++; if (ferr !== 0) $display("FAIL random_framing: %0d bad stop bits, want 0", ferr); else n_pass++;
        n_checks++; if (got.size() !== q.size()) $display("FAIL random_count: got %0d frames want %0d", got.size(), q.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < q.size(); i++) if (i >= got.size() || got[i] !== q[i]) bad++;
        n_checks++; if (bad !== 0) $display("FAIL random_data: %0d wrong bytes, want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int k, k2, w, target, r, lows, c;
        bit p, ack;
        logic [31:0] rd;
        bus_write(8'($urandom()), 4'hF, k, w, p);
        bus_write(8'h00, 4'hF, k2, w, p);
        target = k + 1 + 40 + 4 + 12;
        wait_log(1'b0, target);
        @(negedge clk); #2;
        n_checks++; if (serial_out !== 1'b0) $display("FAIL midframe_precondition: line %b want 0", serial_out); else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++; if (serial_out !== 1'b1) $display("FAIL async_reset_line: got %b want 1", serial_out); else n_pass++;
        n_checks++; if (mem_ready !== 1'b0) $display("FAIL async_reset_ready: got %b want 0", mem_ready); else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        r = line_log.size();
        repeat (100) begin @(posedge clk); #1; end
        lows = 0;
        for (int i = r - 1; i < line_log.size(); i++) if (line_log[i] !== 1'b1) lows++;
        n_checks++; if (lows !== 0) $display("FAIL reset_no_residual: %0d low cycles, want 0", lows); else n_pass++;
        bus_read(rd, c, ack, p);
        n_checks++; if (rd !== 32'h0) $display("FAIL reset_busy_clear: got %h want 00000000", rd); else n_pass++;
    endtask

    task automatic test_fast();
        int k, k1, w, errs, slow;
        byte_q_t q;
        for (int round = 0; round < 2; round++) begin
            q = {};
            for (int i = 0; i < 16; i++) q.push_back(round == 0 ? 8'h0F : 8'($urandom()));
            slow = 0; k1 = 0;
            for (int i = 0; i < 16; i++) begin
                b_write(q[i], k, w);
                if (i == 0) k1 = k;
                if (w >= 400) slow++;
            end
            n_checks++; if (slow !== 0) $display("FAIL fast_write_timeout r%0d: %0d, want 0", round, slow); else n_pass++;
            wait_log(1'b1, k1 + 1 + 16 * 20 + 2);
            errs = line_errors(line_log1, k1 + 1, q, D1);
            n_checks++; if (errs !== 0) $display("FAIL fast_16_frames r%0d: %0d bad cycles, want 0", round, errs); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_enable_gating();
        test_random();
        test_reset_midframe();
        test_fast();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
